perf_counter_unit: RTL and testbench
====================================

PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

Interface
REQ-001 The block SHALL expose parameter N_CH, default 4, number of event channels (1..16).
REQ-002 The block SHALL expose parameter CNT_W, default 32, width of every counter (8..64).
REQ-003 The block SHALL expose parameter CYCLE_LIMIT, default 64, run length in cycles; 0 means unlimited.
REQ-004 The block SHALL expose parameter SATURATE, default 1; 1 = counters hold at all-ones, 0 = counters wrap to zero.
REQ-005 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_i  input  1  asynchronous, active-high reset.
REQ-007 start_i  input  1  level; counting permitted while high.
REQ-008 clear_i  input  1  synchronous clear of live counters, overflow flags and FSM.
REQ-009 event_i  input  N_CH  per-channel event strobe (stall, flush, retire, ...), sampled each cycle.
REQ-010 snap_i  input  1  copy all live counters and overflow flags into shadow registers.
REQ-011 rd_sel_i  input  clog2(N_CH) (min 1)  shadow channel to read.
REQ-012 rd_data_o  output  CNT_W  registered shadow count of channel rd_sel_i.
REQ-013 rd_ovf_o  output  1  registered shadow overflow flag of channel rd_sel_i.
REQ-014 cycle_o  output  CNT_W  live count of cycles spent in RUN.
REQ-015 busy_o  output  1  high in RUN.
REQ-016 done_o  output  1  high in DONE.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN when start_i=1; RUN->IDLE when start_i=0 (pause, counts held); RUN->DONE on the edge where cycle_o becomes CYCLE_LIMIT (CYCLE_LIMIT!=0); DONE->IDLE only on clear_i.
REQ-018 In RUN, cycle_o SHALL increment by 1 per cycle, and channel k SHALL increment by 1 in every cycle with event_i[k]=1; in IDLE and DONE no counter SHALL change.
REQ-019 The first counted cycle SHALL be the cycle in which the FSM is in RUN; the event sampled on the IDLE->RUN edge SHALL NOT be counted.
REQ-020 On increment from all-ones, channel overflow flag SHALL set (sticky) and the count SHALL hold (SATURATE=1) or become 0 (SATURATE=0); cycle_o follows the same rule.
REQ-021 clear_i SHALL zero cycle_o, all live counters and all live overflow flags and force IDLE next cycle; clear_i SHALL take priority over start_i and event_i in the same cycle; shadows SHALL be unaffected.
REQ-022 snap_i SHALL capture the register values present before the same edge's update (i.e. excluding same-cycle events); snap_i with clear_i SHALL capture pre-clear values.
REQ-023 rd_data_o/rd_ovf_o SHALL reflect rd_sel_i with exactly 1 cycle latency; rd_sel_i >= N_CH SHALL return 0 and 0.
REQ-024 A snap_i and a read of the same channel in the same cycle SHALL return the old shadow value; the new value appears one cycle later.

Reset
REQ-025 rst_i=1 SHALL immediately force IDLE and zero all live counters, overflow flags, shadows, rd_data_o, rd_ovf_o, cycle_o; busy_o=0, done_o=0.
REQ-026 Reset asserted mid-RUN SHALL discard all counts; after release counting resumes only via IDLE->RUN.

Structure
REQ-027 FSM state encoding and default parameter constants SHALL live in shared package perf_pkg.
REQ-028 One counter-plus-overflow-flag slice SHALL be a sub-module perf_counter_channel, instantiated N_CH times and once for the cycle counter.

Verification
REQ-029 N_CH=4, start_i=1 for 10 cycles, event_i=4'b0101 every cycle, snap_i, read ch0 and ch1 -> 10/0 and 0/0, cycle_o=10.
REQ-030 CYCLE_LIMIT=64, start_i held high, event_i[2] every cycle -> done_o rises after 64 RUN cycles, ch2=64, counts frozen over next 20 cycles.
REQ-031 CNT_W=8, SATURATE=1, event_i[0] for 300 cycles -> ch0=255, ovf=1; same with SATURATE=0 -> ch0=44, ovf=1.
REQ-032 clear_i and event_i[1] and snap_i in same cycle with ch1=7 -> shadow ch1=7, live ch1=0, FSM IDLE.
REQ-033 Pause: start_i high 5 cycles, low 3, high 5, event_i[3] constant -> ch3=10, cycle_o=10.
REQ-034 rst_i pulsed asynchronously (mid-cycle) in RUN with counts nonzero -> all outputs 0 before next clk_i edge.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared FSM encoding and default build constants for the performance counter unit.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } perf_state_e;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_CYCLE_LIMIT = 64;
  localparam int DEF_SATURATE    = 1;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter_channel.sv
// One counter slice: increments on inc_i, sticky overflow on increment from all-ones,
// then either holds (SATURATE=1) or wraps to zero.
module perf_counter_channel
  import perf_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SATURATE = DEF_SATURATE
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (clr_i) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (inc_i) begin
      if (&r_cnt) begin
        r_ovf <= 1'b1;
        if (SATURATE == 0) r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign cnt_o = r_cnt;
  assign ovf_o = r_ovf;

endmodule

// File: rtl/perf_counter_unit.sv
// Multi-channel event counter with run/pause/limit FSM, shadow snapshot bank and
// registered single-channel readback.
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int CYCLE_LIMIT = DEF_CYCLE_LIMIT,
  parameter int SATURATE    = DEF_SATURATE
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      clear_i,
  input  logic [N_CH-1:0]           event_i,
  input  logic                      snap_i,
  input  logic [sel_w(N_CH)-1:0]    rd_sel_i,
  output logic [CNT_W-1:0]          rd_data_o,
  output logic                      rd_ovf_o,
  output logic [CNT_W-1:0]          cycle_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam logic [CNT_W-1:0] LIMIT_LAST = CNT_W'(CYCLE_LIMIT - 1);

  perf_state_e      r_state;
  logic             r_busy;
  logic             r_done;
  logic             w_run;
  logic             w_hit_limit;
  logic [CNT_W-1:0] w_cycle;
  logic             w_cyc_ovf_unused;
  logic [CNT_W-1:0] w_cnt [N_CH];
  logic [N_CH-1:0]  w_ovf;
  logic [CNT_W-1:0] r_shadow_cnt [N_CH];
  logic [N_CH-1:0]  r_shadow_ovf;
  logic [CNT_W-1:0] r_rd_data;
  logic             r_rd_ovf;

  // Counting is gated on the registered state, so the IDLE->RUN edge never counts.
  assign w_run       = (r_state == ST_RUN) && !clear_i;
  assign w_hit_limit = (CYCLE_LIMIT != 0) && (w_cycle == LIMIT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (clear_i) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (start_i) begin
          r_state <= ST_RUN;
          r_busy  <= 1'b1;
        end
        ST_RUN: if (w_hit_limit) begin
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else if (!start_i) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        ST_DONE: begin
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    perf_counter_channel #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_ch (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .inc_i (w_run & event_i[k]),
      .cnt_o (w_cnt[k]),
      .ovf_o (w_ovf[k])
    );
  end

  perf_counter_channel #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_cycle (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clear_i),
    .inc_i (w_run),
    .cnt_o (w_cycle),
    .ovf_o (w_cyc_ovf_unused)
  );

  // Shadows sample pre-edge live values; readback sees pre-edge shadows.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_CH; k++) r_shadow_cnt[k] <= '0;
      r_shadow_ovf <= '0;
      r_rd_data    <= '0;
      r_rd_ovf     <= 1'b0;
    end else begin
      if (snap_i) begin
        for (int k = 0; k < N_CH; k++) r_shadow_cnt[k] <= w_cnt[k];
        r_shadow_ovf <= w_ovf;
      end
      if (32'(rd_sel_i) < N_CH) begin
        r_rd_data <= r_shadow_cnt[rd_sel_i];
        r_rd_ovf  <= r_shadow_ovf[rd_sel_i];
      end else begin
        r_rd_data <= '0;
        r_rd_ovf  <= 1'b0;
      end
    end
  end

  assign rd_data_o = r_rd_data;
  assign rd_ovf_o  = r_rd_ovf;
  assign cycle_o   = w_cycle;
  assign busy_o    = r_busy;
  assign done_o    = r_done;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Bench for perf_counter_unit: default build plus two 8-bit builds (saturate / wrap).
module tb_perf_counter_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, clear, snap;
  logic [3:0] ev;
  logic [1:0] rd_sel;

  logic [31:0] m_rd_data, m_cycle;
  logic        m_rd_ovf, m_busy, m_done;
  logic [7:0]  s_rd_data, s_cycle, w_rd_data, w_cycle;
  logic        s_rd_ovf, s_busy, s_done, w_rd_ovf, w_busy, w_done;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int          dut;
    logic [63:0] data;
    logic        ovf;
    string       tag;
  } rd_exp_t;
  rd_exp_t sb_q[$];

  always #5 clk = ~clk;

  perf_counter_unit u_main (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .event_i(ev),
    .snap_i(snap), .rd_sel_i(rd_sel), .rd_data_o(m_rd_data), .rd_ovf_o(m_rd_ovf),
    .cycle_o(m_cycle), .busy_o(m_busy), .done_o(m_done)
  );

  perf_counter_unit #(.CNT_W(8), .CYCLE_LIMIT(0), .SATURATE(1)) u_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .event_i(ev),
    .snap_i(snap), .rd_sel_i(rd_sel), .rd_data_o(s_rd_data), .rd_ovf_o(s_rd_ovf),
    .cycle_o(s_cycle), .busy_o(s_busy), .done_o(s_done)
  );

  perf_counter_unit #(.CNT_W(8), .CYCLE_LIMIT(0), .SATURATE(0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .event_i(ev),
    .snap_i(snap), .rd_sel_i(rd_sel), .rd_data_o(w_rd_data), .rd_ovf_o(w_rd_ovf),
    .cycle_o(w_cycle), .busy_o(w_busy), .done_o(w_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_all();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic do_snap();
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  // Expectation is queued as the select is driven, retired once the DUT has registered it.
  task automatic read_ch(input logic [1:0] sel, input int dut, input logic [63:0] d,
                         input logic o, input string tag);
    rd_exp_t e;
    logic [63:0] got_d;
    logic        got_o;
    rd_sel = sel;
    e.dut = dut; e.data = d; e.ovf = o; e.tag = tag;
    sb_q.push_back(e);
    tick();
    e = sb_q.pop_front();
    case (e.dut)
      1:       begin got_d = 64'(s_rd_data); got_o = s_rd_ovf; end
      2:       begin got_d = 64'(w_rd_data); got_o = w_rd_ovf; end
      default: begin got_d = 64'(m_rd_data); got_o = m_rd_ovf; end
    endcase
    chk({e.tag, "_data"}, got_d, e.data);
    chk({e.tag, "_ovf"}, 64'(got_o), 64'(e.ovf));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; snap = 1'b0; ev = 4'b0; rd_sel = 2'd0;
    #12;
    chk("rst_cycle", 64'(m_cycle), 64'd0);
    chk("rst_busy", 64'(m_busy), 64'd0);
    chk("rst_done", 64'(m_done), 64'd0);
    chk("rst_rd_data", 64'(m_rd_data), 64'd0);
    chk("rst_rd_ovf", 64'(m_rd_ovf), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic run: 10 counted cycles with channels 0 and 2 active.
    start = 1'b1; ev = 4'b0101;
    tick();
    chk("first_edge_cycle", 64'(m_cycle), 64'd0);
    chk("first_edge_busy", 64'(m_busy), 64'd1);
    repeat (9) tick();
    start = 1'b0;
    tick();
    ev = 4'b0;
    chk("basic_cycle", 64'(m_cycle), 64'd10);
    chk("basic_busy", 64'(m_busy), 64'd0);
    do_snap();
    read_ch(2'd0, 0, 64'd10, 1'b0, "basic_ch0");
    read_ch(2'd1, 0, 64'd0, 1'b0, "basic_ch1");
    read_ch(2'd2, 0, 64'd10, 1'b0, "basic_ch2");

    // Clear, event and snap together with ch1 = 7.
    clr_all();
    chk("clear_cycle", 64'(m_cycle), 64'd0);
    start = 1'b1; ev = 4'b0010;
    repeat (8) tick();
    clear = 1'b1; snap = 1'b1;
    tick();
    clear = 1'b0; snap = 1'b0; start = 1'b0; ev = 4'b0;
    chk("clrsnap_busy", 64'(m_busy), 64'd0);
    chk("clrsnap_cycle", 64'(m_cycle), 64'd0);
    read_ch(2'd1, 0, 64'd7, 1'b0, "clrsnap_shadow_ch1");
    snap = 1'b1;
    read_ch(2'd1, 0, 64'd7, 1'b0, "snap_same_cycle_old");
    snap = 1'b0;
    read_ch(2'd1, 0, 64'd0, 1'b0, "snap_next_cycle_live0");

    // Pause: 5 high, 3 low, 5 high, ch3 constant.
    clr_all();
    ev = 4'b1000; start = 1'b1;
    repeat (5) tick();
    start = 1'b0;
    repeat (3) tick();
    chk("pause_busy", 64'(m_busy), 64'd0);
    chk("pause_held_cycle", 64'(m_cycle), 64'd5);
    start = 1'b1;
    repeat (5) tick();
    start = 1'b0;
    tick();
    ev = 4'b0;
    chk("pause_cycle", 64'(m_cycle), 64'd10);
    do_snap();
    read_ch(2'd3, 0, 64'd10, 1'b0, "pause_ch3");
    read_ch(2'd0, 0, 64'd0, 1'b0, "pause_ch0");

    // Cycle limit of 64, then frozen in DONE.
    clr_all();
    ev = 4'b0100; start = 1'b1;
    repeat (64) tick();
    chk("limit_pre_done", 64'(m_done), 64'd0);
    chk("limit_pre_cycle", 64'(m_cycle), 64'd63);
    tick();
    chk("limit_done", 64'(m_done), 64'd1);
    chk("limit_busy", 64'(m_busy), 64'd0);
    chk("limit_cycle", 64'(m_cycle), 64'd64);
    repeat (20) tick();
    chk("frozen_cycle", 64'(m_cycle), 64'd64);
    chk("frozen_done", 64'(m_done), 64'd1);
    do_snap();
    read_ch(2'd2, 0, 64'd64, 1'b0, "limit_ch2");
    start = 1'b0; ev = 4'b0;
    clr_all();
    chk("done_cleared", 64'(m_done), 64'd0);

    // 8-bit builds: 300 events on ch0.
    ev = 4'b0001; start = 1'b1;
    tick();
    repeat (299) tick();
    start = 1'b0;
    tick();
    ev = 4'b0;
    chk("sat_cycle", 64'(s_cycle), 64'd255);
    chk("wrap_cycle", 64'(w_cycle), 64'd44);
    do_snap();
    read_ch(2'd0, 1, 64'd255, 1'b1, "sat_ch0");
    read_ch(2'd0, 2, 64'd44, 1'b1, "wrap_ch0");
    read_ch(2'd1, 1, 64'd0, 1'b0, "sat_ch1");

    // Asynchronous reset mid-RUN.
    clr_all();
    ev = 4'b1111; start = 1'b1;
    repeat (5) tick();
    do_snap();
    read_ch(2'd0, 0, 64'd4, 1'b0, "prereset_ch0");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_cycle", 64'(m_cycle), 64'd0);
    chk("async_busy", 64'(m_busy), 64'd0);
    chk("async_rd_data", 64'(m_rd_data), 64'd0);
    chk("async_sat_cycle", 64'(s_cycle), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_reset_first_cycle", 64'(m_cycle), 64'd0);
    chk("post_reset_busy", 64'(m_busy), 64'd1);
    tick();
    chk("post_reset_count", 64'(m_cycle), 64'd1);
    start = 1'b0; ev = 4'b0;
    read_ch(2'd0, 0, 64'd0, 1'b0, "post_reset_shadow");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
